fft_sdf_ctrl: RTL

FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft_sdf_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the single-path delay-feedback FFT stage controller.
package fft_pkg;

    localparam int FFT_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BFLY  = 2'd2,
        DRAIN = 2'd3
    } fft_state_t;

endpackage

// File: rtl/fft_sdf_ctrl.sv
// SDF FFT stage controller: sequences delay-buffer fill, butterfly and drain phases.
// Optional build macro FFT_CTRL_STATS_EN adds a saturating 16-bit completed-frame counter.
module fft_sdf_ctrl
    import fft_pkg::*;
#(
    parameter int DEPTH = FFT_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic          flush,
    output logic          din_ready,
    output logic          sr_shift_en,
    output logic          bfly_en,
    output logic [CW-1:0] tw_idx,
    output logic          dout_valid,
    output logic          frame_done,
    output logic          busy
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    fft_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          out_pending, out_pending_nx;
    logic          frame_done_nx;
    logic          accept;
    logic          cnt_last;

    assign din_ready   = (state != DRAIN);
    assign accept      = din_valid && din_ready;
    assign cnt_last    = (cnt == CNT_LAST);
    assign busy        = (state != IDLE);
    assign sr_shift_en = accept || (state == DRAIN);
    assign bfly_en     = accept && (state == BFLY);
    assign tw_idx      = (state == BFLY) ? cnt : '0;
    assign dout_valid  = (accept && (state == BFLY))
                       || (accept && (state == FILL) && out_pending)
                       || (state == DRAIN);

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no path leaves it unassigned and infers a latch.
        state_nx       = state;
        cnt_nx         = cnt;
        out_pending_nx = out_pending;
        frame_done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = FILL;
                    cnt_nx   = CW'(1);
                end
            end
            FILL: begin
                if (accept) begin
                    if (cnt_last) begin
                        state_nx       = BFLY;
                        cnt_nx         = '0;
                        out_pending_nx = 1'b0;
                        frame_done_nx  = out_pending;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                // A drain only starts on a frame boundary with previous differences still buffered.
                end else if ((cnt == '0) && out_pending && flush) begin
                    state_nx = DRAIN;
                end
            end
            BFLY: begin
                if (accept) begin
                    if (cnt_last) begin
                        state_nx       = FILL;
                        cnt_nx         = '0;
                        out_pending_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_last) begin
                    state_nx       = IDLE;
                    cnt_nx         = '0;
                    out_pending_nx = 1'b0;
                    frame_done_nx  = out_pending;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx       = IDLE;
                cnt_nx         = '0;
                out_pending_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            out_pending <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            out_pending <= out_pending_nx;
            frame_done  <= frame_done_nx;
        end
    end

`ifdef FFT_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
